// File: rtl/tri_raster_bbox_if.sv
// Pixel write port between the rasteriser and the framebuffer.
// The rasteriser drives the request side (master), the framebuffer
// returns px_ready (slave). A pixel transfers on px_valid & px_ready.
interface tri_raster_bbox_if #(
  parameter int CW      = 12,
  parameter int COLOR_W = 1
);

  logic               px_valid;
  logic               px_ready;
  logic [CW-1:0]      px_x;
  logic [CW-1:0]      px_y;
  logic [COLOR_W-1:0] px_data;

  modport master (
    output px_valid,
    output px_x,
    output px_y,
    output px_data,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_x,
    input  px_y,
    input  px_data,
    output px_ready
  );

endinterface

// File: rtl/tri_raster_bbox.sv
// Bounding-box triangle rasteriser.
// Walks NUM_TRI triangles from an external vertex table (addressed by
// tri_idx), scans each triangle's screen-clipped bounding box in row-major
// order and emits every covered pixel on a valid/ready write port.
// Coverage uses three edge functions; either winding order is accepted.
module tri_raster_bbox #(
  parameter int CW        = 12,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int NUM_TRI   = 3,
  parameter int COLOR_W   = 1,
  parameter int INCLUSIVE = 1,
  localparam int IW       = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IW-1:0]      tri_idx,
  input  logic [CW-1:0]      v1x,
  input  logic [CW-1:0]      v1y,
  input  logic [CW-1:0]      v2x,
  input  logic [CW-1:0]      v2y,
  input  logic [CW-1:0]      v3x,
  input  logic [CW-1:0]      v3y,
  input  logic [COLOR_W-1:0] tri_color,
  tri_raster_bbox_if.master  px,
  output logic               busy,
  output logic               done
);

  // Edge values: operands are CW+1-bit signed differences, so a
  // 2*CW+3-bit signed result holds the difference of two products exactly.
  localparam int EW = 2 * CW + 3;

  localparam logic [CW-1:0] XLIM     = CW'(SCR_W - 1);
  localparam logic [CW-1:0] YLIM     = CW'(SCR_H - 1);
  localparam logic [IW-1:0] LAST_TRI = IW'(NUM_TRI - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_SCAN,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      tri_idx_q;
  logic [CW-1:0]      v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic [COLOR_W-1:0] color_q;
  logic [CW-1:0]      xmin_q, xmax_q, ymin_q, ymax_q;
  logic [CW-1:0]      cx_q, cy_q;
  logic               px_valid_q;
  logic [CW-1:0]      px_x_q, px_y_q;
  logic [COLOR_W-1:0] px_data_q;
  logic               busy_q;
  logic               done_q;

  logic [CW-1:0]      bx_min_d, bx_max_d, by_min_d, by_max_d;
  logic               bbox_empty_d;
  logic signed [EW-1:0] area_d;
  logic signed [EW-1:0] e1_d, e2_d, e3_d;
  logic               cur_in_d;
  logic               last_px_d;
  logic [CW-1:0]      cx_d, cy_d;

  // Zero-extend an unsigned coordinate into the signed edge width.
  function automatic logic signed [EW-1:0] sext(input logic [CW-1:0] v);
    return signed'({{(EW-CW){1'b0}}, v});
  endfunction

  // E(q; a, b) = (qx-bx)*(ay-by) - (ax-bx)*(qy-by)
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [CW-1:0] qx, input logic [CW-1:0] qy,
    input logic [CW-1:0] ax, input logic [CW-1:0] ay,
    input logic [CW-1:0] bx, input logic [CW-1:0] by
  );
    logic signed [EW-1:0] t0, t1;
    t0 = (sext(qx) - sext(bx)) * (sext(ay) - sext(by));
    t1 = (sext(ax) - sext(bx)) * (sext(qy) - sext(by));
    return t0 - t1;
  endfunction

  // Same-sign test over the three edges. In inclusive mode zero edges are
  // neutral, but at least one edge must carry a sign.
  function automatic logic inside_fn(
    input logic signed [EW-1:0] a,
    input logic signed [EW-1:0] b,
    input logic signed [EW-1:0] c
  );
    logic pa, pb, pc, na, nb, nc;
    na = a[EW-1];
    nb = b[EW-1];
    nc = c[EW-1];
    pa = !a[EW-1] && (a != '0);
    pb = !b[EW-1] && (b != '0);
    pc = !c[EW-1] && (c != '0);
    if (INCLUSIVE != 0)
      return ((pa || pb || pc) && !(na || nb || nc)) ||
             ((na || nb || nc) && !(pa || pb || pc));
    return (pa && pb && pc) || (na && nb && nc);
  endfunction

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Triangle setup terms, cursor coverage and row-major cursor step.
  always_comb begin
    bx_min_d = min3(v1x_q, v2x_q, v3x_q);
    by_min_d = min3(v1y_q, v2y_q, v3y_q);
    bx_max_d = max3(v1x_q, v2x_q, v3x_q);
    by_max_d = max3(v1y_q, v2y_q, v3y_q);
    if (bx_max_d > XLIM) bx_max_d = XLIM;
    if (by_max_d > YLIM) by_max_d = YLIM;
    // Coordinates are unsigned, so only the max side can clip; a min
    // beyond the clipped max means the box lies fully off screen.
    bbox_empty_d = (bx_min_d > bx_max_d) || (by_min_d > by_max_d);

    area_d = edge_fn(v3x_q, v3y_q, v1x_q, v1y_q, v2x_q, v2y_q);

    e1_d = edge_fn(cx_q, cy_q, v1x_q, v1y_q, v2x_q, v2y_q);
    e2_d = edge_fn(cx_q, cy_q, v2x_q, v2y_q, v3x_q, v3y_q);
    e3_d = edge_fn(cx_q, cy_q, v3x_q, v3y_q, v1x_q, v1y_q);
    cur_in_d = inside_fn(e1_d, e2_d, e3_d);

    last_px_d = (cx_q == xmax_q) && (cy_q == ymax_q);
    cx_d = cx_q;
    cy_d = cy_q;
    if (cx_q != xmax_q) begin
      cx_d = cx_q + CW'(1);
    end else begin
      cx_d = xmin_q;
      cy_d = cy_q + CW'(1);
    end
  end

  // Frame sequencer: triangle fetch, setup, scan/emit and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tri_idx_q  <= '0;
      v1x_q      <= '0;
      v1y_q      <= '0;
      v2x_q      <= '0;
      v2y_q      <= '0;
      v3x_q      <= '0;
      v3y_q      <= '0;
      color_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      px_valid_q <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tri_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          v1x_q   <= v1x;
          v1y_q   <= v1y;
          v2x_q   <= v2x;
          v2y_q   <= v2y;
          v3x_q   <= v3x;
          v3y_q   <= v3y;
          color_q <= tri_color;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          xmin_q <= bx_min_d;
          xmax_q <= bx_max_d;
          ymin_q <= by_min_d;
          ymax_q <= by_max_d;
          cx_q   <= bx_min_d;
          cy_q   <= by_min_d;
          if ((area_d == '0) || bbox_empty_d) state_q <= S_NEXT;
          else                                state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (cur_in_d) begin
            px_x_q     <= cx_q;
            px_y_q     <= cy_q;
            px_data_q  <= color_q;
            px_valid_q <= 1'b1;
            state_q    <= S_EMIT;
          end else if (last_px_d) begin
            state_q <= S_NEXT;
          end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
          end
        end
        S_EMIT: begin
          // Cursor still points at the pixel being emitted until accepted.
          if (px.px_ready) begin
            px_valid_q <= 1'b0;
            if (last_px_d) begin
              state_q <= S_NEXT;
            end else begin
              cx_q    <= cx_d;
              cy_q    <= cy_d;
              state_q <= S_SCAN;
            end
          end
        end
        S_NEXT: begin
          if (tri_idx_q == LAST_TRI) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tri_idx_q <= tri_idx_q + IW'(1);
            state_q   <= S_LOAD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tri_idx     = tri_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign px.px_valid = px_valid_q;
  assign px.px_x     = px_x_q;
  assign px.px_y     = px_y_q;
  assign px.px_data  = px_data_q;

endmodule

// File: tb/tb_tri_raster_bbox.sv
// Bench for tri_raster_bbox: two instances (inclusive and strict coverage)
// share one vertex table and one ready stream. Expected pixels come from a
// full-screen sign-test reference model and are checked by a scoreboard.
module tb_tri_raster_bbox;

  localparam int CW      = 12;
  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int NUM_TRI = 3;
  localparam int COLOR_W = 1;
  localparam int IW      = 2;
  localparam int BUDGET  = 40000;

  typedef struct packed {
    logic [CW-1:0] x1, y1, x2, y2, x3, y3;
    logic [COLOR_W-1:0] col;
  } tri_t;

  typedef struct packed {
    logic [CW-1:0] x, y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  tri_t tab [4];
  logic [IW-1:0] tidx0, tidx1;
  logic busy0, busy1, done0, done1;

  tri_raster_bbox_if #(.CW(CW), .COLOR_W(COLOR_W)) pif0 ();
  tri_raster_bbox_if #(.CW(CW), .COLOR_W(COLOR_W)) pif1 ();

  tri_raster_bbox #(.CW(CW), .SCR_W(SCR_W), .SCR_H(SCR_H), .NUM_TRI(NUM_TRI),
                    .COLOR_W(COLOR_W), .INCLUSIVE(1)) u_inc (
    .clk(clk), .rst_n(rst_n), .start(start), .tri_idx(tidx0),
    .v1x(tab[tidx0].x1), .v1y(tab[tidx0].y1),
    .v2x(tab[tidx0].x2), .v2y(tab[tidx0].y2),
    .v3x(tab[tidx0].x3), .v3y(tab[tidx0].y3),
    .tri_color(tab[tidx0].col), .px(pif0), .busy(busy0), .done(done0));

  tri_raster_bbox #(.CW(CW), .SCR_W(SCR_W), .SCR_H(SCR_H), .NUM_TRI(NUM_TRI),
                    .COLOR_W(COLOR_W), .INCLUSIVE(0)) u_str (
    .clk(clk), .rst_n(rst_n), .start(start), .tri_idx(tidx1),
    .v1x(tab[tidx1].x1), .v1y(tab[tidx1].y1),
    .v2x(tab[tidx1].x2), .v2y(tab[tidx1].y2),
    .v3x(tab[tidx1].x3), .v3y(tab[tidx1].y3),
    .tri_color(tab[tidx1].col), .px(pif1), .busy(busy1), .done(done1));

  int   n_chk = 0;
  int   n_pass = 0;
  pix_t exp_q0 [$];
  pix_t exp_q1 [$];
  int   done_cnt [2];
  int   pix_cnt [2];
  bit   stall [2];
  bit   done_seen [2];
  pix_t held [2];
  int   stall_cnt = 0;
  bit   hold_ready = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input bit ok, input string name, input string det);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, det);
  endtask

  // Reference: plain integer edge function.
  function automatic longint efn(longint qx, longint qy, longint ax, longint ay,
                                 longint bx, longint by);
    return (qx - bx) * (ay - by) - (ax - bx) * (qy - by);
  endfunction

  // Reference model: test every on-screen pixel in row-major order.
  task automatic model_tri(input int k, input tri_t t);
    longint x1, y1, x2, y2, x3, y3, e1, e2, e3, ylo, yhi;
    int npos, nneg;
    bit ins;
    pix_t p;
    x1 = longint'(t.x1); y1 = longint'(t.y1);
    x2 = longint'(t.x2); y2 = longint'(t.y2);
    x3 = longint'(t.x3); y3 = longint'(t.y3);
    if (efn(x3, y3, x1, y1, x2, y2) == 0) return;
    ylo = y1; yhi = y1;
    if (y2 < ylo) ylo = y2;
    if (y3 < ylo) ylo = y3;
    if (y2 > yhi) yhi = y2;
    if (y3 > yhi) yhi = y3;
    for (int y = 0; y < SCR_H; y++) begin
      if (y < ylo || y > yhi) continue;
      for (int x = 0; x < SCR_W; x++) begin
        e1 = efn(x, y, x1, y1, x2, y2);
        e2 = efn(x, y, x2, y2, x3, y3);
        e3 = efn(x, y, x3, y3, x1, y1);
        npos = int'(e1 > 0) + int'(e2 > 0) + int'(e3 > 0);
        nneg = int'(e1 < 0) + int'(e2 < 0) + int'(e3 < 0);
        if (k == 0) ins = (npos > 0 && nneg == 0) || (nneg > 0 && npos == 0);
        else        ins = (npos == 3) || (nneg == 3);
        if (ins) begin
          p.x = CW'(x); p.y = CW'(y); p.c = t.col;
          if (k == 0) exp_q0.push_back(p);
          else        exp_q1.push_back(p);
        end
      end
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input pix_t p,
                     input logic dn, input logic bs);
    pix_t e;
    bit empty;
    if (!rst_n) begin
      stall[k] = 1'b0;
      done_seen[k] = 1'b0;
      return;
    end
    if (stall[k])
      chk(v && (p == held[k]), $sformatf("hold%0d", k),
          $sformatf("got v=%0b (%0d,%0d,%0d) need v=1 (%0d,%0d,%0d)",
                    v, p.x, p.y, p.c, held[k].x, held[k].y, held[k].c));
    if (done_seen[k])
      chk(!dn && !bs, $sformatf("done_pulse%0d", k),
          $sformatf("got done=%0b busy=%0b need 0 0", dn, bs));
    done_seen[k] = dn;
    if (dn) done_cnt[k]++;
    if (v)
      chk((p.x < SCR_W) && (p.y < SCR_H), $sformatf("bounds%0d", k),
          $sformatf("got (%0d,%0d) need x<%0d y<%0d", p.x, p.y, SCR_W, SCR_H));
    if (v && r) begin
      pix_cnt[k]++;
      empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        chk(1'b0, $sformatf("extra_px%0d", k),
            $sformatf("got (%0d,%0d,%0d) need no pixel", p.x, p.y, p.c));
      end else begin
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk(p == e, $sformatf("pixel%0d", k),
            $sformatf("got (%0d,%0d,%0d) need (%0d,%0d,%0d)",
                      p.x, p.y, p.c, e.x, e.y, e.c));
      end
    end
    stall[k] = v && !r;
    held[k]  = p;
  endtask

  // Monitor: sample both outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      mon(0, pif0.px_valid, pif0.px_ready, {pif0.px_x, pif0.px_y, pif0.px_data}, done0, busy0);
      mon(1, pif1.px_valid, pif1.px_ready, {pif1.px_x, pif1.px_y, pif1.px_data}, done1, busy1);
    end
  end

  // Ready driver: forced stalls, random back-pressure or always ready.
  initial begin
    logic r;
    pif0.px_ready = 1'b1;
    pif1.px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) r = 1'b0;
      else if (stall_cnt > 0) begin r = 1'b0; stall_cnt--; end
      else if (rand_rdy) r = ($urandom_range(0, 3) != 0);
      else r = 1'b1;
      pif0.px_ready = r;
      pif1.px_ready = r;
    end
  end

  function automatic tri_t mk_tri(int ax, int ay, int bx, int by, int cx, int cy, int col);
    tri_t t;
    t.x1 = CW'(ax); t.y1 = CW'(ay);
    t.x2 = CW'(bx); t.y2 = CW'(by);
    t.x3 = CW'(cx); t.y3 = CW'(cy);
    t.col = COLOR_W'(col);
    return t;
  endfunction

  function automatic tri_t rand_tri();
    int bx, by;
    bx = ($urandom_range(0, 3) == 0) ? 620 : int'($urandom_range(0, 600));
    by = ($urandom_range(0, 3) == 0) ? 460 : int'($urandom_range(0, 440));
    return mk_tri(bx + int'($urandom_range(0, 24)), by + int'($urandom_range(0, 24)),
                  bx + int'($urandom_range(0, 24)), by + int'($urandom_range(0, 24)),
                  bx + int'($urandom_range(0, 24)), by + int'($urandom_range(0, 24)),
                  int'($urandom_range(0, 1)));
  endfunction

  task automatic run_frame(input string nm, input int stall_c, input int exp0, input int exp1);
    int d0, d1;
    bit fin;
    for (int t = 0; t < NUM_TRI; t++) begin
      model_tri(0, tab[t]);
      model_tri(1, tab[t]);
    end
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    pix_cnt[0] = 0;
    pix_cnt[1] = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (done_cnt[0] > d0 && done_cnt[1] > d1) begin
        fin = 1'b1;
        break;
      end
      if (c == stall_c) stall_cnt = 5;
      if (c == 20 && busy0 && busy1) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk(fin, {nm, "_finish"}, $sformatf("got done counts %0d/%0d need %0d/%0d",
        done_cnt[0], done_cnt[1], d0 + 1, d1 + 1));
    @(negedge clk);
    @(negedge clk);
    chk(exp_q0.size() == 0, {nm, "_left0"}, $sformatf("got %0d pending need 0", exp_q0.size()));
    chk(exp_q1.size() == 0, {nm, "_left1"}, $sformatf("got %0d pending need 0", exp_q1.size()));
    chk(done_cnt[0] == d0 + 1, {nm, "_done0"}, $sformatf("got %0d need %0d", done_cnt[0], d0 + 1));
    chk(done_cnt[1] == d1 + 1, {nm, "_done1"}, $sformatf("got %0d need %0d", done_cnt[1], d1 + 1));
    if (exp0 >= 0) chk(pix_cnt[0] == exp0, {nm, "_count0"}, $sformatf("got %0d need %0d", pix_cnt[0], exp0));
    if (exp1 >= 0) chk(pix_cnt[1] == exp1, {nm, "_count1"}, $sformatf("got %0d need %0d", pix_cnt[1], exp1));
    exp_q0.delete();
    exp_q1.delete();
  endtask

  initial begin
    bit seen;
    tab[0] = mk_tri(0, 0, 3, 0, 0, 3, 1);
    tab[1] = mk_tri(0, 0, 0, 3, 3, 0, 0);
    tab[2] = mk_tri(0, 0, 5, 5, 10, 10, 1);
    tab[3] = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(!pif0.px_valid && !busy0 && !done0 && tidx0 == '0, "rst_ctrl0",
        $sformatf("got v=%0b busy=%0b done=%0b idx=%0d need 0", pif0.px_valid, busy0, done0, tidx0));
    chk(pif0.px_x == '0 && pif0.px_y == '0 && pif0.px_data == '0, "rst_data0",
        $sformatf("got (%0d,%0d,%0d) need 0", pif0.px_x, pif0.px_y, pif0.px_data));
    chk(!pif1.px_valid && !busy1 && !done1 && tidx1 == '0, "rst_ctrl1",
        $sformatf("got v=%0b busy=%0b done=%0b idx=%0d need 0", pif1.px_valid, busy1, done1, tidx1));
    @(negedge clk); #2 rst_n = 1'b1;

    // Right triangle both windings plus a degenerate one
    run_frame("basic", -1, 20, 2);
    // Five-cycle stall in the middle of the scan
    run_frame("stall", 6, 20, 2);

    // Triangle crossing the right and bottom screen edges
    rand_rdy = 1'b1;
    tab[0] = mk_tri(600, 400, 700, 400, 600, 500, 1);
    tab[1] = rand_tri();
    tab[2] = rand_tri();
    run_frame("clip", -1, -1, -1);

    // Asynchronous reset while a pixel waits for acceptance
    rand_rdy = 1'b0;
    hold_ready = 1'b1;
    tab[0] = mk_tri(0, 0, 3, 0, 0, 3, 1);
    tab[1] = mk_tri(0, 0, 0, 3, 3, 0, 0);
    tab[2] = mk_tri(0, 0, 5, 5, 10, 10, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pif0.px_valid) begin seen = 1'b1; break; end
    end
    chk(seen, "emit_reach", "got no px_valid within 50 cycles need px_valid=1");
    #2 rst_n = 1'b0;
    #1;
    chk(!pif0.px_valid && !busy0 && !pif1.px_valid && !busy1, "async_rst",
        $sformatf("got v0=%0b b0=%0b v1=%0b b1=%0b need all 0",
                  pif0.px_valid, busy0, pif1.px_valid, busy1));
    chk(tidx0 == '0 && tidx1 == '0, "async_rst_idx",
        $sformatf("got %0d/%0d need 0/0", tidx0, tidx1));
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    hold_ready = 1'b0;
    run_frame("restart", -1, 20, 2);

    // Random triangles under random back-pressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int t = 0; t < NUM_TRI; t++) tab[t] = rand_tri();
      run_frame($sformatf("rand%0d", f), (f == 0) ? 9 : -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
